uart_rx: RTL and testbench
==========================

# uart_rx

Memory-mapped UART receiver with an 8-entry receive FIFO. It is a bus slave on the machine's CPU bus, alongside `uart`, and uses the same rd/wr/valid handshake as the other peripherals. It deserialises 8N1 frames from the `rx` pin into the FIFO. The CPU drains the FIFO and polls status through three byte-wide registers.

## Interface
- `DIV`, 104: baud divisor in `clk` cycles per bit (12 MHz / 115200); must be ≥ 4.
- `DEPTH`, 8: FIFO entries; must be a power of two.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `addr`  in  3  register select: 0 = DATA, 1 = STATUS, 2 = CTRL; 3–7 are unmapped.
- `rd_en`  in  1  read strobe, one cycle per access.
- `rd_data`  out  8  read data, valid when `rd_valid` = 1.
- `rd_valid`  out  1  read acknowledge.
- `wr_en`  in  1  write strobe.
- `wr_data`  in  8  write data.
- `rx`  in  1  asynchronous serial input; idle level is high.

## Operation
- Input synchroniser:
  - `rx` passes through two flops, both resetting to 1.
  - All frame logic uses the synchronised value `rxs`.
- Receive FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- A baud counter `cnt` of width clog2(DIV) counts down; a *tick* is the cycle in which `cnt` = 0.
- IDLE:
  - If `rxs` = 0: go to START and load `cnt` = DIV/2 − 1 (integer division).
- START, on tick:
  - If `rxs` = 0: go to DATA, set `bitn` = 0, load `cnt` = DIV − 1.
  - Otherwise: go to IDLE; the glitch is rejected and nothing is recorded.
- DATA, on tick:
  - Shift `rxs` into `shreg` bit 7 (shift right), so the frame is received LSB first.
  - Increment `bitn` and reload `cnt` = DIV − 1.
  - After the 8th bit (`bitn` = 7), go to STOP.
- STOP, on tick:
  - If `rxs` = 1: push `shreg` into the FIFO and go to IDLE.
  - If `rxs` = 0: set `ferr`, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: go to IDLE when `rxs` = 1. This prevents a held-low line (break) from retriggering frames.
- FIFO push rules:
  - A push when full drops the byte and sets `ovr`; the FIFO contents are unchanged.
  - A push and a pop in the same cycle are both honoured.
  - When the FIFO is full, a pop in that same cycle frees the slot, so the push succeeds and `ovr` is not set.
- FIFO state: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH; the count is log2(DEPTH)+1 bits.
- Register map:
  - DATA read (`addr` = 0):
    - Non-empty FIFO: returns the head byte and pops it.
    - Empty FIFO: returns 0x00 and nothing changes.
  - STATUS read (`addr` = 1):
    - bit0 = not empty, bit1 = full, bit2 = `ovr`, bit3 = `ferr`.
    - bits 7:4 = count, saturated to 15.
  - CTRL write (`addr` = 2):
    - bit0 = 1 clears `ovr`; bit1 = 1 clears `ferr`.
    - bit7 = 1 flushes the FIFO (pointers and count go to 0).
    - A set event in the same cycle as a clear wins, so the flag stays 1.
  - Writes to `addr` 0, 1 and 3–7 are ignored.
  - Reads of `addr` 2–7 return 0x00 with a normal `rd_valid`.
- `rd_en` and `wr_en` asserted together: both take effect independently.

## Timing
- Reset values (`rst_n` = 0 at a clock edge):
  - FSM = IDLE, `cnt` = 0, `bitn` = 0, `shreg` = 0.
  - FIFO empty, `ovr` = 0, `ferr` = 0.
  - `rd_valid` = 0, `rd_data` = 0x00.
  - Synchroniser flops = 1.
- Reset mid-frame aborts the frame; the partial byte is never pushed.
- Read latency is 1 cycle:
  - `rd_en` at cycle n gives `rd_valid` = 1 and `rd_data` at cycle n+1.
  - `rd_data` is registered.
  - `rd_valid` is 0 in every other cycle, because the machine ORs all slave valids together.
- A DATA pop takes effect at edge n. A second DATA read at n+1 returns the next byte.
- Frame timing, with the falling edge on `rxs` first seen at cycle t:
  - Start-bit sample at t + DIV/2.
  - Data bit k sampled at t + DIV/2 + DIV·(k+1).
  - Stop-bit sample at t + DIV/2 + 9·DIV.
  - The pushed byte is visible in STATUS from the following cycle.
- End-to-end latency from the `rx` pin is 2 cycles longer, due to the synchroniser.

## Test plan
- Reset and idle:
  - Stimulus: `rst_n` low, then high with `rx` = 1.
  - Required: a STATUS read returns 0x00 with `rd_valid` exactly one cycle after `rd_en`; a DATA read returns 0x00.
- Single frame, DIV = 104:
  - Stimulus: send 0xA5 as 8N1.
  - Required: STATUS = 0x11, then DATA = 0xA5, then STATUS = 0x00.
- Fill and overrun:
  - Stimulus: send 9 frames, 0x00 to 0x08, with no reads.
  - Required: STATUS = 0x87; DATA reads yield 0x00 to 0x07; 0x08 is lost.
  - Stimulus: CTRL write 0x01. Required: STATUS bit2 reads 0.
- Framing error and break:
  - Stimulus: send 0x3C with the stop bit held at 0, then keep `rx` low for 3·DIV cycles, then return it high.
  - Required: FIFO empty, STATUS = 0x08, no spurious frames.
  - Stimulus: send 0x55. Required: it is received normally.
- Glitch rejection:
  - Stimulus: pulse `rx` low for DIV/4 cycles.
  - Required: FSM returns to IDLE and STATUS stays 0x00.
- Push/pop collision and wrap:
  - Stimulus: with the FIFO full, issue a DATA read in the exact cycle of a stop-bit push.
  - Required: no overrun and count stays 8.
  - Stimulus: stream 20 bytes while draining.
  - Required: order is preserved across pointer wrap.
  - Stimulus: CTRL write 0x80. Required: STATUS = 0x00.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small receive FIFO behind a
// byte-wide register interface (DATA / STATUS / CTRL).
module uart_rx #(
  parameter int DIV   = 104,
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] addr,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rx
);

  localparam int CW = $clog2(DIV);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t          state, state_next;
  logic            sync_ff, rxs;
  logic [CW-1:0]   cnt;
  logic [2:0]      bitn;
  logic [7:0]      shreg;
  logic            tick;
  logic            load_half, load_full, shift_en, bit_clr, push, ferr_set;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [NW-1:0]   count;
  logic            empty, full, data_rd, pop, ctrl_wr, flush, push_ok, ovr_set;
  logic            ovr, ferr;
  logic [7:0]      status;

  // Count field of STATUS is four bits wide; larger FIFOs report 15.
  function automatic logic [3:0] sat_count(input logic [NW-1:0] c);
    logic [31:0] w;
    w = 32'(c);
    return (w > 32'd15) ? 4'hF : w[3:0];
  endfunction

  assign tick = (cnt == '0);

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_ff <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      sync_ff <= rx;
      rxs     <= sync_ff;
    end
  end

  // Receive FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Receive FSM next-state logic; bit sampling happens only on ticks.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!rxs) state_next = START;
      START:     if (tick) state_next = rxs ? IDLE : DATA;
      DATA:      if (tick && bitn == 3'd7) state_next = STOP;
      STOP:      if (tick) state_next = rxs ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxs) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Receive FSM outputs: counter loads, shifting and the stop-bit verdict.
  always_comb begin
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    bit_clr   = 1'b0;
    push      = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE:  load_half = !rxs;
      START: if (tick && !rxs) begin
        load_full = 1'b1;
        bit_clr   = 1'b1;
      end
      DATA:  if (tick) begin
        shift_en  = 1'b1;
        load_full = 1'b1;
      end
      STOP:  if (tick) begin
        push     = rxs;
        ferr_set = !rxs;
      end
      default: ;
    endcase
  end

  // Baud counter, bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      bitn  <= 3'd0;
      shreg <= 8'h00;
    end else begin
      if (load_half)      cnt <= HALF;
      else if (load_full) cnt <= FULL;
      else if (!tick)     cnt <= cnt - 1'b1;
      if (bit_clr)        bitn <= 3'd0;
      else if (shift_en)  bitn <= bitn + 3'd1;
      if (shift_en)       shreg <= {rxs, shreg[7:1]};
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == NW'(DEPTH));
  assign data_rd = rd_en && (addr == 3'd0);
  assign pop     = data_rd && !empty;
  assign ctrl_wr = wr_en && (addr == 3'd2);
  assign flush   = ctrl_wr && wr_data[7];
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign push_ok = push && (!full || pop);
  assign ovr_set = push && full && !pop;
  assign status  = {sat_count(count), ferr, ovr, full, !empty};

  // FIFO storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= shreg;
  end

  // FIFO pointers and occupancy; a flush overrides any push or pop.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as a clear keeps the flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= ovr_set  | (ovr  & !(ctrl_wr && wr_data[0]));
      ferr <= ferr_set | (ferr & !(ctrl_wr && wr_data[1]));
    end
  end

  // Registered read port with single-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        case (addr)
          3'd0:    rd_data <= empty ? 8'h00 : mem[rp];
          3'd1:    rd_data <= status;
          default: rd_data <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with hand-computed expectations.
module tb_uart_rx;
  localparam int DIV = 104;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] addr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rx;

  int checks   = 0;
  int failures = 0;

  uart_rx #(.DIV(DIV), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_en(wr_en),
    .wr_data(wr_data), .rx(rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
    addr  = a;
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    check("rd_valid", {7'b0, rd_valid}, 8'h01);
    d = rd_data;
  endtask

  task automatic read_expect(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    reg_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    cyc(1);
    wr_en   = 1'b0;
  endtask

  // One 8N1 frame; the line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(DIV);
    end
    rx = stop;
    cyc(DIV);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run time exceeded, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] b;
    logic [7:0] q[$];

    rst_n = 1'b0; rx = 1'b1; addr = 3'd0; rd_en = 1'b0;
    wr_en = 1'b0; wr_data = 8'h00;
    cyc(3);
    check("reset_rd_valid", {7'b0, rd_valid}, 8'h00);
    check("reset_rd_data", rd_data, 8'h00);
    rst_n = 1'b1;
    cyc(2);
    read_expect("idle_status", 3'd1, 8'h00);
    cyc(1);
    check("rd_valid_one_cycle", {7'b0, rd_valid}, 8'h00);
    read_expect("idle_data_empty", 3'd0, 8'h00);

    // Single frame
    send_frame(8'hA5, 1'b1);
    read_expect("single_status", 3'd1, 8'h11);
    read_expect("single_data", 3'd0, 8'hA5);
    read_expect("single_status_after", 3'd1, 8'h00);

    // Fill and overrun
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1);
    read_expect("ovr_status", 3'd1, 8'h87);
    for (int i = 0; i < 8; i++) read_expect("ovr_drain", 3'd0, 8'(i));
    read_expect("ovr_empty_status", 3'd1, 8'h04);
    reg_write(3'd2, 8'h01);
    read_expect("ovr_cleared", 3'd1, 8'h00);

    // Framing error followed by a held-low break
    send_frame(8'h3C, 1'b0);
    cyc(3 * DIV);
    rx = 1'b1;
    cyc(2 * DIV);
    read_expect("ferr_status", 3'd1, 8'h08);
    reg_write(3'd0, 8'h83);
    reg_write(3'd1, 8'h83);
    reg_write(3'd5, 8'h83);
    read_expect("ignored_writes", 3'd1, 8'h08);
    read_expect("ctrl_reads_zero", 3'd2, 8'h00);
    read_expect("unmapped_reads_zero", 3'd6, 8'h00);
    send_frame(8'h55, 1'b1);
    read_expect("after_break_status", 3'd1, 8'h19);
    read_expect("after_break_data", 3'd0, 8'h55);
    reg_write(3'd2, 8'h02);
    read_expect("ferr_cleared", 3'd1, 8'h00);

    // Glitch shorter than half a bit
    rx = 1'b0;
    cyc(DIV / 4);
    rx = 1'b1;
    cyc(2 * DIV);
    read_expect("glitch_status", 3'd1, 8'h00);
    send_frame(8'h81, 1'b1);
    read_expect("post_glitch_status", 3'd1, 8'h11);
    read_expect("post_glitch_data", 3'd0, 8'h81);

    // Full FIFO: pop in the exact cycle of the stop-bit push
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b1);
    read_expect("full_status", 3'd1, 8'h83);
    fork
      send_frame(8'h18, 1'b1);
      begin
        cyc(990);
        addr  = 3'd0;
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        check("collide_rd_valid", {7'b0, rd_valid}, 8'h01);
        check("collide_data", rd_data, 8'h10);
      end
    join
    read_expect("collide_status", 3'd1, 8'h83);
    for (int i = 1; i < 9; i++) read_expect("collide_drain", 3'd0, 8'(8'h10 + i));

    // Streaming across pointer wrap with one byte of lag
    for (int i = 0; i < 20; i++) begin
      b = 8'(i * 37) ^ 8'hC3;
      send_frame(b, 1'b1);
      q.push_back(b);
      if (i > 0) read_expect("stream_data", 3'd0, q.pop_front());
    end
    read_expect("stream_last", 3'd0, q.pop_front());
    read_expect("stream_status", 3'd1, 8'h00);

    // Flush
    send_frame(8'h66, 1'b1);
    send_frame(8'h99, 1'b1);
    read_expect("preflush_status", 3'd1, 8'h21);
    reg_write(3'd2, 8'h80);
    read_expect("flush_status", 3'd1, 8'h00);
    read_expect("flush_data", 3'd0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
